sr_control_mc: RTL and testbench

SR_CONTROL_MC -- requirements
Module: sr_control_mc

---
 rtl/sr_control_mc.sv | 100 ++++++++++
 tb/tb_sr_control_mc.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/sr_control_mc.sv
// sr_control_mc: multi-cycle control FSM for schoolRISCV with data-memory handshake, wait timeout and sticky trap
module sr_control_mc #(
  parameter bit ENABLE_MEM  = 1'b1,
  parameter bit ENABLE_BLT  = 1'b1,
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             instrValid,
  output logic             instrReady,
  input  logic [6:0]       cmdOp,
  input  logic [2:0]       cmdF3,
  input  logic [6:0]       cmdF7,
  input  logic             aluZero,
  input  logic             aluSlt,
  output logic             pcWrite,
  output logic             pcSrc,
  output logic             regWrite,
  output logic             aluSrc,
  output logic [1:0]       wdSrc,
  output logic [2:0]       aluControl,
  output logic             memReq,
  output logic             memWe,
  input  logic             memAck,
  output logic             trap,
  output logic [1:0]       trapCause,
  output logic [CNT_W-1:0] instret
);
  localparam logic [2:0] ALU_ADD = 3'd0, ALU_OR = 3'd1, ALU_SRL = 3'd2, ALU_SLTU = 3'd3, ALU_SUB = 3'd4;
  typedef enum logic [2:0] {S_FETCH, S_EXEC, S_MEM, S_WB, S_TRAP} state_t;
  state_t           state_q;
  logic [6:0]       op_q, f7_q;
  logic [2:0]       f3_q;
  logic [7:0]       wait_q;
  logic [1:0]       cause_q;
  logic [CNT_W-1:0] instret_q;
  logic [9:0]       fn;
  logic             is_r, is_addi, is_lui, is_br, is_lw, is_sw, legal, taken, ex, mem, wb;
  logic [2:0]       r_alu;
  assign fn      = {f7_q, f3_q};
  assign is_r    = op_q == 7'b0110011 && (fn == 10'h000 || fn == 10'h100 || fn == 10'h006 || fn == 10'h005 || fn == 10'h003);
  assign r_alu   = fn == 10'h100 ? ALU_SUB : f3_q == 3'd6 ? ALU_OR : f3_q == 3'd5 ? ALU_SRL : f3_q == 3'd3 ? ALU_SLTU : ALU_ADD;
  assign is_addi = op_q == 7'b0010011 && f3_q == 3'd0;
  assign is_lui  = op_q == 7'b0110111;
  assign is_br   = op_q == 7'b1100011 && (f3_q[2:1] == 2'b00 || (ENABLE_BLT && f3_q[2:1] == 2'b10));
  assign is_lw   = ENABLE_MEM && op_q == 7'b0000011 && f3_q == 3'd2;
  assign is_sw   = ENABLE_MEM && op_q == 7'b0100011 && f3_q == 3'd2;
  assign legal   = is_r || is_addi || is_lui || is_br || is_lw || is_sw;
  // f3[2] selects the signed-compare pair, f3[0] inverts the condition
  assign taken   = f3_q[2] ? aluSlt ^ f3_q[0] : aluZero ^ f3_q[0];
  assign ex      = state_q == S_EXEC;
  assign mem     = state_q == S_MEM;
  assign wb      = state_q == S_WB;
  assign instrReady = state_q == S_FETCH && !rst;
  assign pcWrite    = (ex && (is_r || is_addi || is_lui || is_br)) || (mem && is_sw && memAck) || wb;
  assign pcSrc      = ex && is_br && taken;
  assign regWrite   = (ex && (is_r || is_addi || is_lui)) || wb;
  assign aluSrc     = (ex && (is_addi || is_lw || is_sw)) || mem;
  assign wdSrc      = wb ? 2'd2 : (ex && is_lui) ? 2'd1 : 2'd0;
  assign aluControl = (ex && is_r) ? r_alu : (ex && is_br) ? ALU_SUB : ALU_ADD;
  assign memReq     = mem;
  assign memWe      = mem && is_sw;
  assign trap       = state_q == S_TRAP;
  assign trapCause  = cause_q;
  assign instret    = instret_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_FETCH;
      op_q      <= '0;
      f3_q      <= '0;
      f7_q      <= '0;
      wait_q    <= '0;
      cause_q   <= '0;
      instret_q <= '0;
    end else begin
      instret_q <= instret_q + CNT_W'(pcWrite);
      case (state_q)
        S_FETCH: if (instrValid) begin
          op_q    <= cmdOp;
          f3_q    <= cmdF3;
          f7_q    <= cmdF7;
          state_q <= S_EXEC;
        end
        S_EXEC: begin
          wait_q  <= '0;
          state_q <= !legal ? S_TRAP : (is_lw || is_sw) ? S_MEM : S_FETCH;
          if (!legal) cause_q <= 2'd1;
        end
        S_MEM: if (memAck) state_q <= is_lw ? S_WB : S_FETCH;
        else if (wait_q == 8'(MEM_TIMEOUT - 1)) begin
          state_q <= S_TRAP;
          cause_q <= 2'd2;
        end else wait_q <= wait_q + 8'd1;
        S_WB: state_q <= S_FETCH;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_sr_control_mc.sv
// tb_sr_control_mc: two configurations driven in lockstep, checked cycle-by-cycle against an instruction-level model
module tb_sr_control_mc;
  logic clk = 0, rst = 0, instrValid = 0, aluZero = 0, aluSlt = 0, memAck = 0;
  logic [6:0] cmdOp = 0, cmdF7 = 0;
  logic [2:0] cmdF3 = 0;
  logic a_ir, a_pw, a_ps, a_rw, a_as, a_mr, a_mw, a_tr, b_ir, b_pw, b_ps, b_rw, b_as, b_mr, b_mw, b_tr;
  logic [1:0] a_wd, a_tc, b_wd, b_tc;
  logic [2:0] a_ac, b_ac;
  logic [31:0] a_ret;
  logic [3:0] b_ret;
  int n_cmp = 0, n_bad = 0;
  bit en = 0;
  localparam logic [16:0] ADD = {7'h00, 3'd0, 7'h33}, BNE = {7'h00, 3'd1, 7'h63}, BLT = {7'h00, 3'd4, 7'h63};
  localparam logic [16:0] LW = {7'h00, 3'd2, 7'h03}, SW = {7'h00, 3'd2, 7'h23}, ADDI = {7'h55, 3'd0, 7'h13};
  logic [16:0] tbl [13] = '{ADD, {7'h20, 3'd0, 7'h33}, {7'h00, 3'd6, 7'h33}, {7'h00, 3'd5, 7'h33}, {7'h00, 3'd3, 7'h33},
                           ADDI, {7'h12, 3'd0, 7'h37}, {7'h00, 3'd0, 7'h63}, BNE, BLT, {7'h00, 3'd5, 7'h63}, LW, SW};
  sr_control_mc u_a (
    .clk(clk), .rst(rst), .instrValid(instrValid), .instrReady(a_ir), .cmdOp(cmdOp), .cmdF3(cmdF3), .cmdF7(cmdF7),
    .aluZero(aluZero), .aluSlt(aluSlt), .pcWrite(a_pw), .pcSrc(a_ps), .regWrite(a_rw), .aluSrc(a_as), .wdSrc(a_wd),
    .aluControl(a_ac), .memReq(a_mr), .memWe(a_mw), .memAck(memAck), .trap(a_tr), .trapCause(a_tc), .instret(a_ret)
  );
  sr_control_mc #(.ENABLE_MEM(1'b0), .ENABLE_BLT(1'b0), .MEM_TIMEOUT(3), .CNT_W(4)) u_b (
    .clk(clk), .rst(rst), .instrValid(instrValid), .instrReady(b_ir), .cmdOp(cmdOp), .cmdF3(cmdF3), .cmdF7(cmdF7),
    .aluZero(aluZero), .aluSlt(aluSlt), .pcWrite(b_pw), .pcSrc(b_ps), .regWrite(b_rw), .aluSrc(b_as), .wdSrc(b_wd),
    .aluControl(b_ac), .memReq(b_mr), .memWe(b_mw), .memAck(memAck), .trap(b_tr), .trapCause(b_tc), .instret(b_ret)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask
  // model: per instance, where it is in the instruction's life (0 wait fetch, 1 exec, 2 mem, 3 wb, 4 dead)
  int ph [2], wt [2];
  logic [16:0] mins [2];
  logic [1:0] mcause [2];
  logic [31:0] mret [2];
  function automatic int ralu(input logic [6:0] f7, input logic [2:0] f3);
    case ({f7, f3})
      10'b0000000_000: return 0;
      10'b0100000_000: return 4;
      10'b0000000_110: return 1;
      10'b0000000_101: return 2;
      10'b0000000_011: return 3;
      default: return -1;
    endcase
  endfunction
  // 0 illegal, 1 R-type, 2 ADDI, 3 LUI, 4 branch, 5 LW, 6 SW; instance 1 has memory and BLT/BGE gated off
  function automatic int kind(input int k, input logic [16:0] e);
    logic [6:0] op = e[6:0];
    logic [2:0] f3 = e[9:7];
    case (op)
      7'h33: return ralu(e[16:10], f3) >= 0 ? 1 : 0;
      7'h13: return f3 == 0 ? 2 : 0;
      7'h37: return 3;
      7'h63: return (f3 == 0 || f3 == 1 || (k == 0 && (f3 == 4 || f3 == 5))) ? 4 : 0;
      7'h03: return (k == 0 && f3 == 2) ? 5 : 0;
      7'h23: return (k == 0 && f3 == 2) ? 6 : 0;
      default: return 0;
    endcase
  endfunction
  function automatic logic [46:0] expect_out(input int k);
    logic ir = 0, pw = 0, ps = 0, rw = 0, as = 0, mr = 0, mw = 0, tr = 0;
    logic [1:0] wd = 0;
    logic [2:0] ac = 0;
    int c = kind(k, mins[k]);
    if (!rst) begin
      case (ph[k])
        0: ir = 1;
        1: begin
          rw = c inside {1, 2, 3};
          pw = c inside {1, 2, 3, 4};
          as = c inside {2, 5, 6};
          wd = c == 3 ? 2'd1 : 2'd0;
          ac = c == 1 ? 3'(ralu(mins[k][16:10], mins[k][9:7])) : c == 4 ? 3'd4 : 3'd0;
          ps = c == 4 && (mins[k][9] ? aluSlt ^ mins[k][7] : aluZero ^ mins[k][7]);
        end
        2: begin
          mr = 1;
          as = 1;
          mw = c == 6;
          pw = c == 6 && memAck;
        end
        3: begin
          rw = 1;
          wd = 2;
          pw = 1;
        end
        default: tr = 1;
      endcase
    end
    return {ir, pw, ps, rw, as, wd, ac, mr, mw, tr, rst ? 2'd0 : mcause[k], rst ? 32'd0 : mret[k]};
  endfunction
  task automatic step(input int k);
    logic [46:0] e = expect_out(k);
    int c = kind(k, mins[k]);
    int tmo = k == 0 ? 15 : 3;
    if (rst) begin
      ph[k] = 0; wt[k] = 0; mret[k] = 0; mcause[k] = 0; mins[k] = 0;
    end else begin
      if (e[45]) mret[k] = (mret[k] + 1) & (k == 0 ? 32'hFFFF_FFFF : 32'hF);
      case (ph[k])
        0: if (instrValid) begin mins[k] = {cmdF7, cmdF3, cmdOp}; ph[k] = 1; end
        1: begin
          ph[k] = c == 0 ? 4 : c >= 5 ? 2 : 0;
          if (c == 0) mcause[k] = 1;
          wt[k] = 0;
        end
        2: if (memAck) ph[k] = c == 5 ? 3 : 0;
        else if (wt[k] + 1 == tmo) begin ph[k] = 4; mcause[k] = 2; end
        else wt[k]++;
        3: ph[k] = 0;
        default: ;
      endcase
    end
  endtask
  always @(negedge clk) if (en) begin
    chk("dut0 outputs", {a_ir, a_pw, a_ps, a_rw, a_as, a_wd, a_ac, a_mr, a_mw, a_tr, a_tc, a_ret}, expect_out(0));
    chk("dut1 outputs", {b_ir, b_pw, b_ps, b_rw, b_as, b_wd, b_ac, b_mr, b_mw, b_tr, b_tc, 28'd0, b_ret}, expect_out(1));
    step(0);
    step(1);
  end
  task automatic go(input logic r, v, input logic [16:0] e, input logic z, s, ack);
    @(posedge clk);
    #1;
    rst = r; instrValid = v; cmdOp = e[6:0]; cmdF3 = e[9:7]; cmdF7 = e[16:10];
    aluZero = z; aluSlt = s; memAck = ack;
    @(negedge clk);
    #1;
  endtask
  task automatic ins(input logic [16:0] e);
    go(0, 1, e, 0, 0, 0);
  endtask
  task automatic nop(input logic z, s, ack);
    go(0, 0, 17'd0, z, s, ack);
  endtask
  initial begin
    logic [16:0] e;
    #1 rst = 1;
    en = 1;
    go(1, 0, 17'd0, 0, 0, 0);
    chk("reset instrReady", a_ir, 0);
    chk("reset aluControl", a_ac, 0);
    chk("reset memReq", a_mr, 0);
    chk("reset instret", a_ret, 0);
    ins(ADD);
    chk("ready after reset", a_ir, 1);
    nop(0, 0, 0);
    chk("add regWrite", a_rw, 1);
    chk("add pcWrite", a_pw, 1);
    chk("add aluControl", a_ac, 0);
    nop(0, 0, 0);
    chk("add instret", a_ret, 1);
    ins(BNE);
    nop(0, 0, 0);
    chk("bne taken pcSrc", a_ps, 1);
    chk("bne taken pcWrite", a_pw, 1);
    ins(BNE);
    nop(1, 0, 0);
    chk("bne not-taken pcSrc", a_ps, 0);
    chk("bne not-taken pcWrite", a_pw, 1);
    ins(BLT);
    nop(0, 1, 0);
    chk("blt enabled pcSrc", a_ps, 1);
    nop(0, 0, 0);
    chk("blt gated trap", b_tr, 1);
    chk("blt gated cause", b_tc, 1);
    chk("blt gated ready", b_ir, 0);
    ins(LW);
    nop(0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      nop(0, 0, i == 3);
      chk("lw memReq", a_mr, 1);
    end
    nop(0, 0, 0);
    chk("lw wb regWrite", a_rw, 1);
    chk("lw wb wdSrc", a_wd, 2);
    nop(0, 0, 0);
    chk("lw instret", a_ret, 5);
    ins(SW);
    nop(0, 0, 0);
    for (int i = 0; i < 15; i++) begin
      nop(0, 0, 0);
      chk("sw wait memWe", a_mw, 1);
    end
    nop(0, 0, 0);
    chk("timeout trap", a_tr, 1);
    chk("timeout cause", a_tc, 2);
    repeat (3) begin
      nop(0, 0, 1);
      chk("trapped ready", a_ir, 0);
    end
    go(1, 0, 17'd0, 0, 0, 0);
    ins(SW);
    nop(0, 0, 0);
    repeat (14) nop(0, 0, 0);
    nop(0, 0, 1);
    chk("late ack pcWrite", a_pw, 1);
    chk("late ack no trap", a_tr, 0);
    nop(0, 0, 0);
    chk("late ack ready", a_ir, 1);
    chk("late ack instret", a_ret, 1);
    ins(LW);
    nop(0, 0, 0);
    nop(0, 0, 0);
    #1 rst = 1;
    #1;
    chk("async rst memReq", a_mr, 0);
    chk("async rst pcWrite", a_pw, 0);
    chk("async rst regWrite", a_rw, 0);
    chk("async rst instret", a_ret, 0);
    go(1, 0, 17'd0, 0, 0, 0);
    for (int i = 0; i < 16; i++) begin
      ins(ADDI);
      if (i == 15) chk("cnt4 before wrap", b_ret, 15);
      nop(0, 0, 0);
    end
    nop(0, 0, 0);
    chk("cnt4 wrapped", b_ret, 0);
    chk("cnt32 after 16", a_ret, 16);
    repeat (3000) begin
      e = tbl[$urandom_range(0, 12)];
      if ($urandom_range(0, 19) == 0) e = 17'($urandom);
      if (e[6:0] == 7'h13) e[16:10] = 7'($urandom);
      go($urandom_range(0, 99) < 3, 1'($urandom), e, 1'($urandom), 1'($urandom), $urandom_range(0, 3) == 0);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
